// File: rtl/mux_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mux_arbiter_if
// Description : Request/grant bundle between the four Mux requesters and
//               the round-robin arbiter that owns the Mux selector.
//               master : arbiter side (drives gnt/selector/busy/timeout)
//               slave  : requester side (drives req)
// Signals     : req[NREQ-1:0]  request, bit i = Mux input i (a,b,c,d)
//               gnt[NREQ-1:0]  one-hot registered grant
//               selector[1:0]  Mux selector
//               busy           a grant is active
//               timeout        one-cycle revoke pulse
// Revision    : 1.0 - initial release
// ============================================================================
interface mux_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [1:0]      selector;
    logic            busy;
    logic            timeout;

    modport master (
        input  req,
        output gnt,
        output selector,
        output busy,
        output timeout
    );

    modport slave (
        output req,
        input  gnt,
        input  selector,
        input  busy,
        input  timeout
    );
endinterface
`default_nettype wire

// File: rtl/mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux_arbiter
// Description : Round-robin arbiter sharing the 4:1 16-bit Mux among four
//               requesters. Issues a registered one-hot grant, drives the Mux
//               selector and inserts one idle turnaround cycle between owners
//               so the Mux output never switches source mid-transfer.
// Ports       : clk         rising-edge clock
//               rst         synchronous active-high reset
//               bus.req     requests (held high for the whole ownership)
//               bus.gnt     one-hot grant
//               bus.selector Mux selector, holds last owner while idle
//               bus.busy    any grant active
//               bus.timeout one-cycle pulse on forced revoke
// Config      : define MUX_ARB_TIMEOUT_EN to bound each grant to TIMEOUT
//               cycles; without it grants are unbounded and timeout is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 8
) (
    input  wire logic     clk,
    input  wire logic     rst,
    mux_arbiter_if.master bus
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [1:0]      r_ptr, w_ptr_nxt;
    logic [1:0]      r_owner, w_owner_nxt;
    logic [1:0]      r_sel, w_sel_nxt;
    logic [NREQ-1:0] r_gnt, w_gnt_nxt;
    logic            r_busy, w_busy_nxt;
    logic            r_timeout, w_timeout_nxt;

    logic            w_found;
    logic [1:0]      w_pick;
    logic            w_expire;

    localparam logic [NREQ-1:0] c_ONE = {{(NREQ-1){1'b0}}, 1'b1};

    // Parameter legality; an out-of-range TIMEOUT would not fit the counter.
    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range_bad
        $error("mux_arbiter: TIMEOUT must be within 2..255");
    end

    // First requester at or after r_ptr, wrapping modulo 4. The 2-bit add
    // provides the wrap for free.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        for (int k = 0; k < 4; k++) begin
            if (!w_found && bus.req[r_ptr + 2'(k)]) begin
                w_found = 1'b1;
                w_pick  = r_ptr + 2'(k);
            end
        end
    end

`ifdef MUX_ARB_TIMEOUT_EN
    // Counts OWN cycles already completed; zero on the grant edge, so the
    // edge that would finish TIMEOUT cycles of gnt sees TIMEOUT-1.
    localparam logic [7:0] c_CNT_LAST = 8'(TIMEOUT - 1);
    logic [7:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 8'd0;
        end else if (r_state == OWN) begin
            r_cnt <= r_cnt + 8'd1;
        end else begin
            r_cnt <= 8'd0;
        end
    end

    assign w_expire = (r_cnt == c_CNT_LAST);
`else
    assign w_expire = 1'b0;
`endif

    // Next-state and output logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_owner_nxt   = r_owner;
        w_sel_nxt     = r_sel;
        w_gnt_nxt     = r_gnt;
        w_busy_nxt    = r_busy;
        w_timeout_nxt = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_owner_nxt = w_pick;
                    w_gnt_nxt   = c_ONE << w_pick;
                    w_sel_nxt   = w_pick;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = OWN;
                end
            end
            OWN: begin
                // A voluntary release wins over an expiry on the same edge,
                // so timeout only pulses when the owner still wanted the bus.
                if (!bus.req[r_owner] || w_expire) begin
                    w_gnt_nxt     = '0;
                    w_busy_nxt    = 1'b0;
                    w_ptr_nxt     = r_owner + 2'd1;
                    w_timeout_nxt = bus.req[r_owner];
                    w_state_nxt   = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ptr     <= 2'd0;
            r_owner   <= 2'd0;
            r_sel     <= 2'd0;
            r_gnt     <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_owner   <= w_owner_nxt;
            r_sel     <= w_sel_nxt;
            r_gnt     <= w_gnt_nxt;
            r_busy    <= w_busy_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign bus.gnt      = r_gnt;
    assign bus.selector = r_sel;
    assign bus.busy     = r_busy;
    assign bus.timeout  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_arbiter
// Description : Self-checking bench for mux_arbiter. A behavioural model
//               (owner index or -1, round-robin start, grant age) predicts
//               gnt/selector/busy/timeout each cycle; directed scenarios add
//               fixed expectations. Honours MUX_ARB_TIMEOUT_EN with TIMEOUT=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_arbiter;

    localparam int c_TIMEOUT = 4;
`ifdef MUX_ARB_TIMEOUT_EN
    localparam bit c_TO_EN = 1'b1;
`else
    localparam bit c_TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    mux_arbiter_if #(.NREQ(4)) ifc ();

    mux_arbiter #(
        .NREQ    (4),
        .TIMEOUT (c_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    // The shared Mux datapath the arbiter steers.
    logic [15:0] mux_in [4];
    logic [15:0] mux_out;
    assign mux_out = mux_in[ifc.selector];

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- behavioural reference model ----------------
    int m_owner = -1;   // -1 = nobody owns the Mux
    int m_ptr   = 0;
    int m_sel   = 0;
    int m_age   = 0;    // cycles gnt has been high including the current one
    bit m_to    = 1'b0;

    function automatic int first_req(logic [3:0] r, int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_owner <= -1;
            m_ptr   <= 0;
            m_sel   <= 0;
            m_age   <= 0;
            m_to    <= 1'b0;
        end else begin
            m_to <= 1'b0;
            if (m_owner < 0) begin
                if (ifc.req != 4'b0) begin
                    m_owner <= first_req(ifc.req, m_ptr);
                    m_sel   <= first_req(ifc.req, m_ptr);
                    m_age   <= 1;
                end
            end else if (!ifc.req[m_owner]) begin
                m_owner <= -1;
                m_ptr   <= (m_owner + 1) % 4;
            end else if (c_TO_EN && m_age == c_TIMEOUT) begin
                m_owner <= -1;
                m_ptr   <= (m_owner + 1) % 4;
                m_to    <= 1'b1;
            end else begin
                m_age <= m_age + 1;
            end
        end
    end

    // {gnt, selector, busy, timeout}
    function automatic logic [7:0] exp_vec();
        logic [3:0] g;
        g = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        return {g, 2'(m_sel), (m_owner >= 0), m_to};
    endfunction

    logic [7:0] dut_vec;
    assign dut_vec = {ifc.gnt, ifc.selector, ifc.busy, ifc.timeout};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst     = 1'b1;
        ifc.req = 4'b0000;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        ifc.req = 4'b0000;
        rst     = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (dut_vec !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_values: {gnt,sel,busy,to}=%b required 00000000", dut_vec);
        end
        rst     = 1'b0;
        ifc.req = 4'b0001;
        tick();
        n_cmp++;
        if (ifc.gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_first_grant: gnt=%b required 0001", ifc.gnt);
        end
        ifc.req = 4'b0000;
        tick();                 // release moves the start index to 1
        ifc.req = 4'b0001;
        tick();
        n_cmp++;
        if (dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_regrant_model: got %b required %b", dut_vec, exp_vec());
        end
        rst = 1'b1;             // reset while requester 0 owns the Mux
        tick();
        n_cmp++;
        if (dut_vec !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_mid_grant: {gnt,sel,busy,to}=%b required 00000000", dut_vec);
        end
        rst     = 1'b0;
        ifc.req = 4'b0011;
        tick();
        n_cmp++;
        if (ifc.gnt !== 4'b0001 || ifc.selector !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_ptr_cleared: gnt=%b sel=%0d required 0001/0", ifc.gnt, ifc.selector);
        end
        ifc.req = 4'b0000;
        tick();
    endtask

    task automatic test_single();
        reset_dut();
        for (int i = 0; i < 4; i++) mux_in[i] = 16'($urandom);
        ifc.req = 4'b0010;
        tick();
        n_cmp++;
        if (ifc.gnt !== 4'b0010 || ifc.selector !== 2'd1 || mux_out !== mux_in[1]) begin
            n_fail++;
            $display("FAIL single_grant: gnt=%b sel=%0d out=%h required 0010/1/%h",
                     ifc.gnt, ifc.selector, mux_out, mux_in[1]);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL single_hold %0d: got %b required %b", i, dut_vec, exp_vec());
            end
        end
        ifc.req = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (ifc.gnt !== 4'b0000 || ifc.selector !== 2'd1 || ifc.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL single_release %0d: gnt=%b sel=%0d busy=%b required 0000/1/0",
                         i, ifc.gnt, ifc.selector, ifc.busy);
            end
        end
    endtask

    task automatic test_round_robin();
        reset_dut();
        ifc.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++;
            if (ifc.gnt !== 4'(1 << (k % 4)) || ifc.selector !== 2'(k % 4)) begin
                n_fail++;
                $display("FAIL rr_order %0d: gnt=%b sel=%0d required %b/%0d",
                         k, ifc.gnt, ifc.selector, 4'(1 << (k % 4)), k % 4);
            end
            for (int h = 0; h < 2; h++) begin
                tick();
                n_cmp++;
                if (dut_vec !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL rr_hold %0d.%0d: got %b required %b", k, h, dut_vec, exp_vec());
                end
            end
            ifc.req[k % 4] = 1'b0;
            tick();
            n_cmp++;
            if (ifc.gnt !== 4'b0000 || ifc.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_gap %0d: gnt=%b busy=%b required 0000/0", k, ifc.gnt, ifc.busy);
            end
            ifc.req = 4'b1111;
        end
        ifc.req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_wrap();
        reset_dut();
        ifc.req = 4'b1000;
        tick();
        ifc.req = 4'b1001;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (ifc.gnt !== 4'b1000 || ifc.selector !== 2'd3) begin
                n_fail++;
                $display("FAIL wrap_hold %0d: gnt=%b sel=%0d required 1000/3", i, ifc.gnt, ifc.selector);
            end
        end
        ifc.req = 4'b0001;
        tick();
        ifc.req = 4'b1001;
        tick();
        n_cmp++;
        if (ifc.gnt !== 4'b0001 || ifc.selector !== 2'd0) begin
            n_fail++;
            $display("FAIL wrap_next: gnt=%b sel=%0d required 0001/0", ifc.gnt, ifc.selector);
        end
        ifc.req = 4'b0000;
        tick();
    endtask

    task automatic test_no_preempt();
        reset_dut();
        ifc.req = 4'b0010;
        tick();
        ifc.req = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (ifc.gnt !== 4'b0010) begin
                n_fail++;
                $display("FAIL no_preempt %0d: gnt=%b required 0010", i, ifc.gnt);
            end
        end
        ifc.req = 4'b0101;      // owner 1 drops, 2 arrives on the same edge
        tick();
        n_cmp++;
        if (ifc.gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL simul_idle: gnt=%b required 0000", ifc.gnt);
        end
        tick();
        n_cmp++;
        if (ifc.gnt !== 4'b0100 || ifc.selector !== 2'd2) begin
            n_fail++;
            $display("FAIL simul_next: gnt=%b sel=%0d required 0100/2", ifc.gnt, ifc.selector);
        end
        ifc.req = 4'b0000;
        tick();
    endtask

    task automatic test_timeout();
        logic [3:0] eg;
        logic       et;
        reset_dut();
        ifc.req = 4'b0100;
        for (int t = 1; t <= 25; t++) begin
            tick();
            et = c_TO_EN && (t % 5 == 0);
            eg = et ? 4'b0000 : 4'b0100;
            n_cmp++;
            if (ifc.gnt !== eg || ifc.timeout !== et || dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL timeout_seq %0d: gnt=%b to=%b vec=%b required %b/%b vec=%b",
                         t, ifc.gnt, ifc.timeout, dut_vec, eg, et, exp_vec());
            end
        end
        // Release on the very edge the limit would be reached.
        reset_dut();
        ifc.req = 4'b0100;
        for (int t = 0; t < 4; t++) tick();
        ifc.req = 4'b0000;
        tick();
        n_cmp++;
        if (ifc.gnt !== 4'b0000 || ifc.timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_vs_release: gnt=%b to=%b required 0000/0", ifc.gnt, ifc.timeout);
        end
    endtask

    task automatic test_random();
        reset_dut();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 2) == 0) ifc.req = 4'($urandom);
            if ($urandom_range(0, 15) == 0) mux_in[$urandom_range(0, 3)] = 16'($urandom);
            tick();
            n_cmp++;
            if (dut_vec !== exp_vec() || !$onehot0(ifc.gnt) || ifc.busy !== (|ifc.gnt)
                || mux_out !== mux_in[m_sel]) begin
                n_fail++;
                $display("FAIL random %0d: req=%b got %b required %b out=%h",
                         i, ifc.req, dut_vec, exp_vec(), mux_out);
            end
        end
        rst     = 1'b0;
        ifc.req = 4'b0000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) mux_in[i] = 16'(i * 16'h1111);
        ifc.req = 4'b0000;
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_no_preempt();
        test_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_arbiter.md
# mux_arbiter

Round-robin arbiter that shares the 4:1, 16-bit `Mux` datapath among four requesters. It owns the Mux `selector` and issues one-hot grants with a request/hold handshake. It also inserts one turnaround cycle between owners, so the Mux output never switches sources mid-transfer.

## Interface
Parameters:
- `NREQ` — default 4; number of requesters. Fixed at 4 to match the Mux inputs a, b, c, d.
- `TIMEOUT` — default 8; maximum grant length in cycles. Used only when `MUX_ARB_TIMEOUT_EN` is defined; legal range 2..255.

Ports:
- `clk` — in, 1; single clock, rising edge.
- `rst` — in, 1; synchronous, active-high reset.
- `req` — in, 4; request, bit i = Mux input i (0=a, 1=b, 2=c, 3=d); held high for the whole ownership.
- `gnt` — out, 4; one-hot grant, registered.
- `selector` — out, 2; drives the Mux selector, registered.
- `busy` — out, 1; high while any grant is active.
- `timeout` — out, 1; one-cycle pulse when a grant is revoked; constant 0 when the macro is absent.

## Operation
State machine: two states, `IDLE` and `OWN`.

Internal registers:
- `ptr[1:0]`: round-robin start index; reset value 0.
- `owner[1:0]`: current owner index.

IDLE:
- If `req` == 0, stay in IDLE.
- Otherwise pick the first i with `req[i]`=1, searching `ptr`, `ptr`+1, … mod 4.
- Set `owner`=i, `gnt`=1<<i, `selector`=i, `busy`=1, and go to OWN.

OWN:
- While `req[owner]`=1, hold `gnt`, `selector` and `busy`.
- When `req[owner]`=0 is sampled: `gnt`=0, `busy`=0, `ptr`=`owner`+1 (mod 4, so 3 wraps to 0), go to IDLE.
- Requests from other requesters during OWN are ignored and never preempt the owner.

`selector` keeps the last owner's value while IDLE; it changes only on a new grant.

Invariants:
- `gnt` is always zero or one-hot.
- `busy` == |`gnt`.
- `selector` == index of the set `gnt` bit whenever `busy`=1.

Reset:
- Values: `gnt`=0, `selector`=0, `busy`=0, `timeout`=0, `ptr`=0, state=IDLE.
- `rst` overrides everything at that edge, including an active grant mid-ownership.
- Requests are not sampled at an edge where `rst`=1.

## Timing
- Grant latency: `req[i]` sampled high at edge k in IDLE gives `gnt[i]`/`selector` valid after edge k, i.e. one cycle.
- Release: `req[owner]` sampled low at edge k gives `gnt`=0 after edge k.
- Turnaround: at least one IDLE cycle between consecutive grants, even if other requests are pending. Back-to-back owners are therefore separated by exactly one cycle with `gnt`=0.
- Single requester with `req` held high continuously keeps the grant indefinitely (macro absent).
- Release and a new request arriving at the same edge: release takes effect; the new request is evaluated at the next edge with the updated `ptr`.

## Configuration
Macro: `MUX_ARB_TIMEOUT_EN`.

Defined:
- An 8-bit counter clears on grant and increments each OWN cycle.
- On the edge that would complete `TIMEOUT` cycles of `gnt` high, the arbiter forces release: `gnt`=0, `busy`=0, `ptr`=`owner`+1, `timeout`=1 for one cycle, go to IDLE.
- A revoked requester that keeps `req` high re-competes normally under round-robin.
- If `req[owner]` drops on the same edge the timeout fires, the event is a normal release and `timeout` stays 0.

Absent:
- No counter is built, grants are unbounded, and `timeout` is tied to 0.

## Test plan
- **Reset mid-grant:** grant `req`=0001, then assert `rst` for 1 cycle → `gnt`=0000, `selector`=0, `busy`=0 after that edge; next grant searches from index 0.
- **Single requester:** `req`=0010 → `gnt`=0010 and `selector`=01 one cycle later; Mux `out` equals input b. Drop `req` → `gnt`=0000 next cycle, `selector` stays 01.
- **Round-robin fairness:** `req`=1111 held, each owner releases after 3 cycles of `gnt` (drop own bit for 1 cycle, then re-raise) → grant order 0,1,2,3,0, with one `gnt`=0000 cycle between each.
- **Wrap-around:** owner 3 releases while `req`=1001 → next grant is index 0 (`selector`=00), not 3.
- **No preemption / simultaneous events:** owner 1 holds; assert `req[0]` → `gnt` stays 0010. Drop `req[1]` and raise `req[2]` on the same edge → 1 idle cycle, then `gnt`=0100.
- **Timeout (macro defined, `TIMEOUT`=4):** `req`=0100 held → `gnt`=0100 for exactly 4 cycles, then `timeout` pulses 1 cycle with `gnt`=0000, then re-grant 0100 one cycle later. With the macro absent, `gnt` stays high for 20+ cycles and `timeout`=0.
